// File: rtl/mas_alu_arbiter.sv
// -----------------------------------------------------------------------------
// mas_alu_arbiter
//
// Round-robin arbiter and sequencer that shares one mas_alu_top instance
// between N issuing units. One command/operand pair is accepted at a time.
// It is presented to the ALU with a req/cmd/op handshake, and the result is
// returned to the requester that was granted. A watchdog turns a silent ALU
// into an error response.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   req_valid  [N]    per-requester command valid (held until req_ready)
//   req_cmd    [N*CMD_W] packed commands, requester i at [i*CMD_W +: CMD_W]
//   req_op1    [N*BLEN]  packed operand 1, requester i at [i*BLEN +: BLEN]
//   req_op2    [N*BLEN]  packed operand 2, requester i at [i*BLEN +: BLEN]
//   req_ready  [N]    one-hot, one-cycle accept pulse (ISSUE state)
//   rsp_valid  [N]    one-hot, one-cycle response pulse (RESP state)
//   rsp_res    [BLEN] result, held until the next response or reset
//   rsp_err           watchdog timeout flag, qualified by rsp_valid
//   busy              high whenever the sequencer is not IDLE
//   mas_alu_req/cmd/op1/op2  request side of the shared ALU
//   mas_alu_res/ready        result side of the shared ALU
//
// This file also holds mas_alu_arbiter_chk, a protocol checker for the
// one-hot/handshake invariants. Simulation environments can bind or
// instantiate it.
// -----------------------------------------------------------------------------

module mas_alu_arbiter_chk #(
    parameter int N = 4
) (
    input logic         clk,
    input logic         rst_n,
    input logic [N-1:0] req_ready,
    input logic [N-1:0] rsp_valid,
    input logic         busy,
    input logic         mas_alu_req
);

    // At most one requester is accepted or answered in any cycle.
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_valid));

    // An accept pulse coincides with the first ALU request cycle.
    a_ready_req: assert property (@(posedge clk) disable iff (!rst_n)
        (req_ready != {N{1'b0}}) |-> (busy && mas_alu_req));

    // The response cycle has already released the ALU.
    a_rsp_noreq: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid != {N{1'b0}}) |-> (busy && !mas_alu_req));

endmodule

module mas_alu_arbiter #(
    parameter int N       = 4,
    parameter int BLEN    = 32,
    parameter int CMD_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*CMD_W-1:0]   req_cmd,
    input  logic [N*BLEN-1:0]    req_op1,
    input  logic [N*BLEN-1:0]    req_op2,
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         rsp_valid,
    output logic [BLEN-1:0]      rsp_res,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 mas_alu_req,
    output logic [CMD_W-1:0]     mas_alu_cmd,
    output logic [BLEN-1:0]      mas_alu_op1,
    output logic [BLEN-1:0]      mas_alu_op2,
    input  logic [BLEN-1:0]      mas_alu_res,
    input  logic                 mas_alu_ready
);

    // A single requester still needs a 1-bit index so the vectors stay legal.
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam int unsigned N_U = N;

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [WD_W-1:0]  WD_ZERO  = {WD_W{1'b0}};
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]   grant_q,     grant_d;
    logic [CMD_W-1:0]   cmd_q,       cmd_d;
    logic [BLEN-1:0]    op1_q,       op1_d;
    logic [BLEN-1:0]    op2_q,       op2_d;
    logic [WD_W-1:0]    wd_q,        wd_d;
    logic [N-1:0]       req_ready_q, req_ready_d;
    logic [N-1:0]       rsp_valid_q, rsp_valid_d;
    logic [BLEN-1:0]    rsp_res_q,   rsp_res_d;
    logic               rsp_err_q,   rsp_err_d;
    logic               busy_q,      busy_d;
    logic               alu_req_q,   alu_req_d;
    logic [IDX_W-1:0]   pick_s;

    // First valid index at or above ptr, searching upward with wrap-around.
    // When nothing is valid the pointer itself is returned, and the caller
    // does not use it.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N-1:0]     valid,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned off = 0; off < N_U; off++) begin
            idx = (32'(ptr) + off) % N_U;
            if (!found && valid[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [N-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] vec;
        for (int i = 0; i < N; i++) begin
            vec[i] = (idx == IDX_W'(i));
        end
        return vec;
    endfunction

    // Next-state, capture and watchdog logic; outputs decoded from next state.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        cmd_d     = cmd_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        wd_d      = wd_q;
        rsp_res_d = rsp_res_q;
        rsp_err_d = rsp_err_q;
        pick_s    = rr_pick(req_valid, rr_ptr_q);

        case (state_q)
            ST_IDLE: begin
                if (req_valid != {N{1'b0}}) begin
                    // The operands are latched here. A requester that drops
                    // valid before req_ready is still served.
                    grant_d = pick_s;
                    cmd_d   = req_cmd[32'(pick_s) * CMD_W +: CMD_W];
                    op1_d   = req_op1[32'(pick_s) * BLEN +: BLEN];
                    op2_d   = req_op2[32'(pick_s) * BLEN +: BLEN];
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The ALU needs at least one cycle, so ready is ignored here.
                wd_d    = WD_ZERO;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mas_alu_ready) begin
                    // A ready on the last watchdog cycle still wins.
                    rsp_res_d = mas_alu_res;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (wd_q == WD_LAST) begin
                    rsp_res_d = {BLEN{1'b0}};
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    wd_d    = (wd_q == WD_LAST) ? wd_q : (wd_q + WD_ONE);
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                // The requester just served becomes the lowest priority.
                rr_ptr_d = (grant_q == IDX_LAST) ? IDX_ZERO : (grant_q + IDX_ONE);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Decoding from the next state lets every output come from a flop.
        if (state_d == ST_ISSUE) begin
            req_ready_d = idx_onehot(grant_d);
        end else begin
            req_ready_d = {N{1'b0}};
        end

        if (state_d == ST_RESP) begin
            rsp_valid_d = idx_onehot(grant_d);
        end else begin
            rsp_valid_d = {N{1'b0}};
        end

        if ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) begin
            alu_req_d = 1'b1;
        end else begin
            alu_req_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDX_ZERO;
            grant_q     <= IDX_ZERO;
            cmd_q       <= {CMD_W{1'b0}};
            op1_q       <= {BLEN{1'b0}};
            op2_q       <= {BLEN{1'b0}};
            wd_q        <= WD_ZERO;
            req_ready_q <= {N{1'b0}};
            rsp_valid_q <= {N{1'b0}};
            rsp_res_q   <= {BLEN{1'b0}};
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            alu_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cmd_q       <= cmd_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            wd_q        <= wd_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            alu_req_q   <= alu_req_d;
        end
    end

    // The latched command and operands go straight to the ALU. They are held
    // unchanged from ISSUE until the next capture.
    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_res     = rsp_res_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign mas_alu_req = alu_req_q;
    assign mas_alu_cmd = cmd_q;
    assign mas_alu_op1 = op1_q;
    assign mas_alu_op2 = op2_q;

endmodule

// File: tb/tb_mas_alu_arbiter.sv
module tb_mas_alu_arbiter;

    localparam int N       = 4;
    localparam int BLEN    = 32;
    localparam int CMD_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;
    localparam int NV      = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N*CMD_W-1:0]   req_cmd = '0;
    logic [N*BLEN-1:0]    req_op1 = '0;
    logic [N*BLEN-1:0]    req_op2 = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         rsp_valid;
    logic [BLEN-1:0]      rsp_res;
    logic                 rsp_err;
    logic                 busy;
    logic                 mas_alu_req;
    logic [CMD_W-1:0]     mas_alu_cmd;
    logic [BLEN-1:0]      mas_alu_op1;
    logic [BLEN-1:0]      mas_alu_op2;
    logic [BLEN-1:0]      mas_alu_res = '0;
    logic                 mas_alu_ready = 1'b0;

    always #5 clk = ~clk;

    mas_alu_arbiter #(.N(N), .BLEN(BLEN), .CMD_W(CMD_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_err(rsp_err),
        .busy(busy), .mas_alu_req(mas_alu_req), .mas_alu_cmd(mas_alu_cmd),
        .mas_alu_op1(mas_alu_op1), .mas_alu_op2(mas_alu_op2),
        .mas_alu_res(mas_alu_res), .mas_alu_ready(mas_alu_ready)
    );

    mas_alu_arbiter_chk #(.N(N)) chk_i (
        .clk(clk), .rst_n(rst_n), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .busy(busy), .mas_alu_req(mas_alu_req)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference ALU: cmd 0 adds, anything else XORs.
    function automatic logic [BLEN-1:0] alu_fn(input logic [CMD_W-1:0] c,
                                               input logic [BLEN-1:0] a,
                                               input logic [BLEN-1:0] b);
        return (c == 4'h0) ? (a + b) : (a ^ b);
    endfunction

    function automatic int lat_exp(input int lat);
        return ((lat < TIMEOUT) ? lat : TIMEOUT) + 1;
    endfunction

    // ---------------- ALU model: ready in the L-th WAIT cycle -------------
    int alu_lat  = 1;
    int exp_len  = 2;
    bit len_chk  = 1'b1;
    int req_cnt  = 0;
    int stab_err = 0;
    logic [CMD_W-1:0] s_cmd;
    logic [BLEN-1:0]  s_op1, s_op2;

    always @(negedge clk) begin
        if (mas_alu_req === 1'b1) begin
            req_cnt++;
            if (req_cnt == 1) begin
                s_cmd = mas_alu_cmd;
                s_op1 = mas_alu_op1;
                s_op2 = mas_alu_op2;
            end else if (mas_alu_cmd !== s_cmd || mas_alu_op1 !== s_op1 || mas_alu_op2 !== s_op2) begin
                stab_err++;
            end
            mas_alu_res   = alu_fn(mas_alu_cmd, mas_alu_op1, mas_alu_op2);
            mas_alu_ready = (req_cnt == alu_lat + 1);
        end else begin
            if (req_cnt != 0 && len_chk) chk("alu_req_len", 64'(req_cnt), 64'(exp_len));
            req_cnt       = 0;
            mas_alu_ready = 1'b0;
            mas_alu_res   = 32'hDEAD_BEEF;
        end
    end

    // ---------------- scoreboard ----------------------------------------
    typedef struct {
        int              idx;
        logic [BLEN-1:0] res;
        logic            err;
    } exp_t;
    exp_t sb_q[$];
    int   gr_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && rsp_valid !== '0) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(oh(e.idx)));
                chk("rsp_res", 64'(rsp_res), 64'(e.res));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------------------------
    task automatic set_req(input int i, input logic [CMD_W-1:0] c,
                           input logic [BLEN-1:0] a, input logic [BLEN-1:0] b);
        req_cmd[i*CMD_W +: CMD_W] = c;
        req_op1[i*BLEN +: BLEN]   = a;
        req_op2[i*BLEN +: BLEN]   = b;
    endtask

    task automatic push_exp(input int i, input logic [BLEN-1:0] r, input logic e);
        exp_t x;
        x.idx = i; x.res = r; x.err = e;
        sb_q.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_res"},   64'(rsp_res),   64'(0));
        chk({tag, "_rsp_err"},   64'(rsp_err),   64'(0));
        chk({tag, "_busy"},      64'(busy),      64'(0));
        chk({tag, "_alu_req"},   64'(mas_alu_req), 64'(0));
        chk({tag, "_alu_cmd"},   64'(mas_alu_cmd), 64'(0));
        chk({tag, "_alu_op1"},   64'(mas_alu_op1), 64'(0));
        chk({tag, "_alu_op2"},   64'(mas_alu_op2), 64'(0));
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 64'(sb_q.size()), 64'(0));
    endtask

    // Applies req_valid from the caller. It compares every accept pulse with
    // the expected grant order, and keep holds requests after they are accepted.
    task automatic run_grants(input bit keep, input int nops);
        int got, cyc, g;
        got = 0; cyc = 0;
        while (got < nops && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (req_ready !== '0) begin
                if (gr_q.size() == 0) begin
                    chk("grant_extra", 64'(req_ready), 64'(0));
                end else begin
                    g = gr_q.pop_front();
                    chk("grant_order", 64'(req_ready), 64'(oh(g)));
                end
                got++;
                if (!keep) req_valid = req_valid & ~req_ready;
                if (got == nops) req_valid = '0;
            end
        end
        if (got < nops) chk("grant_timeout", 64'(got), 64'(nops));
        drain("grant_drain");
    endtask

    typedef struct {
        int              idx;
        logic [CMD_W-1:0] cmd;
        logic [BLEN-1:0] op1;
        logic [BLEN-1:0] op2;
        int              lat;
        logic [BLEN-1:0] res;
        logic            err;
    } vec_t;
    vec_t vecs[NV];

    initial begin
        #100000;
        $display("FAIL tb_timeout simulation exceeded its time limit");
        $fatal(1, "tb_timeout");
    end

    initial begin
        int n;
        logic [CMD_W-1:0] c1;
        logic [BLEN-1:0]  a1, b1;

        vecs[0] = '{2, 4'h0, 32'd5,         32'd7,         2,     32'd12,        1'b0};
        vecs[1] = '{0, 4'h1, 32'h0000_F0F0, 32'h0000_0FF0, 1,     32'h0000_FF00, 1'b0};
        vecs[2] = '{3, 4'h0, 32'hFFFF_FFFF, 32'd1,         3,     32'd0,         1'b0};
        vecs[3] = '{1, 4'h0, 32'd100,       32'd23,        5,     32'd123,       1'b0};
        vecs[4] = '{2, 4'h0, 32'd1,         32'd2,         NEVER, 32'd0,         1'b1};
        vecs[5] = '{3, 4'h1, 32'hAAAA_5555, 32'hFFFF_0000, 16,    32'h5555_5555, 1'b0};
        vecs[6] = '{0, 4'h0, 32'd3,         32'd4,         15,    32'd7,         1'b0};
        vecs[7] = '{0, 4'h1, 32'h1234_5678, 32'h1234_5678, 4,     32'd0,         1'b0};

        // Reset held three cycles with quiet inputs.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Table: one request at a time, latency and hold checked per vector.
        for (int v = 0; v < NV; v++) begin
            alu_lat = vecs[v].lat;
            exp_len = lat_exp(vecs[v].lat);
            set_req(vecs[v].idx, vecs[v].cmd, vecs[v].op1, vecs[v].op2);
            push_exp(vecs[v].idx, vecs[v].res, vecs[v].err);
            req_valid[vecs[v].idx] = 1'b1;
            @(negedge clk);
            chk("req_ready_lat", 64'(req_ready), 64'(oh(vecs[v].idx)));
            chk("busy_on", 64'(busy), 64'(1));
            req_valid = '0;
            n = 0;
            while (rsp_valid === '0 && n < TIMEOUT + 10) begin
                @(negedge clk);
                n++;
            end
            chk("rsp_latency", 64'(n), 64'(lat_exp(vecs[v].lat)));
            @(negedge clk);
            chk("busy_idle", 64'(busy), 64'(0));
            chk("rsp_res_hold", 64'(rsp_res), 64'(vecs[v].res));
        end

        // Valid withdrawn right after capture: the operation still completes.
        alu_lat = 2; exp_len = 3;
        set_req(1, 4'h0, 32'd40, 32'd2);
        push_exp(1, 32'd42, 1'b0);
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("late_drop_ready", 64'(req_ready), 64'(oh(1)));
        drain("late_drop_drain");

        // Stability: every requester's data changes while the ALU is busy.
        alu_lat = 6; exp_len = 7;
        c1 = 4'h1; a1 = 32'hCAFE_0001; b1 = 32'h0F0F_0F0F;
        set_req(1, c1, a1, b1);
        push_exp(1, alu_fn(c1, a1, b1), 1'b0);
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("stab_ready", 64'(req_ready), 64'(oh(1)));
        req_valid = '0;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            req_cmd = 16'($urandom);
            req_op1 = {$urandom, $urandom, $urandom, $urandom};
            req_op2 = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            n++;
        end
        chk("stab_drain", 64'(sb_q.size()), 64'(0));
        chk("alu_stable", 64'(stab_err), 64'(0));

        // Reset in WAIT: operation abandoned, no response afterwards.
        alu_lat = NEVER; len_chk = 1'b0;
        set_req(1, 4'h0, 32'd9, 32'd9);
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("wait_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rst_wait");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_wait_idle", 64'(busy), 64'(0));
        len_chk = 1'b1;

        // Round robin from pointer 0 with all requesters continuously valid.
        alu_lat = 2; exp_len = 3;
        for (int i = 0; i < N; i++) set_req(i, 4'h0, BLEN'(i), 32'd10);
        for (int k = 0; k < 5; k++) begin
            gr_q.push_back(k % N);
            push_exp(k % N, BLEN'(10 + (k % N)), 1'b0);
        end
        req_valid = 4'b1111;
        run_grants(1'b1, 5);

        // Serve requester 3 so the pointer wraps to 0.
        set_req(3, 4'h0, 32'd7, 32'd8);
        gr_q.push_back(3);
        push_exp(3, 32'd15, 1'b0);
        req_valid = 4'b1000;
        run_grants(1'b0, 1);

        // Pointer wrap: 0 and 3 both valid, so 0 goes first.
        set_req(0, 4'h0, 32'd20, 32'd1);
        set_req(3, 4'h1, 32'h0000_00FF, 32'h0000_000F);
        gr_q.push_back(0); gr_q.push_back(3);
        push_exp(0, 32'd21, 1'b0);
        push_exp(3, 32'h0000_00F0, 1'b0);
        req_valid = 4'b1001;
        run_grants(1'b0, 2);

        @(negedge clk);
        chk("final_busy", 64'(busy), 64'(0));
        chk("final_stable", 64'(stab_err), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
